// File: rtl/clock_divide_checker_if.sv
// Bundles the checker's enable, clock-under-test and result signals.
// The bench/driver side uses master; the checker itself uses slave.
interface clock_divide_checker_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             div_clk;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_len;
  logic             period_valid;

  modport master (
    output en, div_clk,
    input  locked, err, period, high_len, period_valid
  );

  modport slave (
    input  en, div_clk,
    output locked, err, period, high_len, period_valid
  );
endinterface

// File: rtl/clock_divide_checker.sv
// Divided-clock health checker: measures period/high time of div_clk in clk_in cycles.
// Define CLK_DIV_CHECK_SYNC_EN to add a 2-flop synchronizer when div_clk is asynchronous.
//
// state  | meaning
// IDLE   | disabled, waiting for en
// ACQ    | waiting for first rise to establish phase
// MEAS   | counting consecutive good periods
// LOCKED | ratio confirmed, watching for faults
// ERR    | fault seen while locked, held until en=0 or reset
module clock_divide_checker #(
  parameter int DIV        = 2,
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic                   clk_in,
  input  logic                   reset,
  clock_divide_checker_if.slave  chk
);

  typedef enum logic [2:0] {IDLE, ACQ, MEAS, LOCKED, ERR} state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] EXP_PER  = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] EXP_HIGH = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(2 * DIV);
  localparam logic [GW-1:0]    LOCK_N   = GW'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic             s_q, s_prev_q;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] high_tmp_q, high_tmp_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             samp_in;

`ifdef CLK_DIV_CHECK_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= chk.div_clk;
      sync2_q <= sync1_q;
    end
  end

  assign samp_in = sync2_q;
`else
  assign samp_in = chk.div_clk;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      s_q        <= 1'b0;
      s_prev_q   <= 1'b0;
      run_cnt_q  <= '0;
      high_tmp_q <= '0;
      good_cnt_q <= '0;
      period_q   <= '0;
      high_len_q <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= samp_in;
      s_prev_q   <= s_q;
      run_cnt_q  <= run_cnt_d;
      high_tmp_q <= high_tmp_d;
      good_cnt_q <= good_cnt_d;
      period_q   <= period_d;
      high_len_q <= high_len_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  logic          rise, fall, good, timeout, report;
  logic [GW-1:0] good_inc;

  always_comb begin
    rise     = s_q & ~s_prev_q;
    fall     = ~s_q & s_prev_q;
    // run_cnt at a rise is the full period; at a fall it is the high time
    good     = (run_cnt_q == EXP_PER) && (high_tmp_q == EXP_HIGH);
    timeout  = !rise && (run_cnt_q >= TMO);
    good_inc = good_cnt_q + GW'(1);

    run_cnt_d  = rise ? CNT_W'(1)
               : ((run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CNT_W'(1));
    high_tmp_d = fall ? run_cnt_q : high_tmp_q;

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    report     = 1'b0;

    if (!chk.en) begin
      state_d    = IDLE;
      good_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ACQ;
          good_cnt_d = '0;
        end
        ACQ: begin
          if (rise) begin
            state_d    = MEAS;
            good_cnt_d = '0;
          end
        end
        MEAS: begin
          if (rise) begin
            report = 1'b1;
            if (good) begin
              good_cnt_d = good_inc;
              if (good_inc == LOCK_N) state_d = LOCKED;
            end else begin
              good_cnt_d = '0;
            end
          end else if (timeout) begin
            state_d    = ACQ;
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (rise) begin
            report = 1'b1;
            if (!good) state_d = ERR;
          end else if (timeout) begin
            state_d = ERR;
          end
        end
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end

    period_d   = report ? run_cnt_q  : period_q;
    high_len_d = report ? high_tmp_q : high_len_q;
    valid_d    = report;
    locked_d   = (state_d == LOCKED);
    err_d      = err_q | (state_d == ERR);
  end

  assign chk.locked       = locked_q;
  assign chk.err          = err_q;
  assign chk.period       = period_q;
  assign chk.high_len     = high_len_q;
  assign chk.period_valid = valid_q;

endmodule

// File: tb/tb_clock_divide_checker.sv
// Scoreboard bench: generators push expected period/high_len per generated period,
// monitors pop and compare on every period_valid pulse.
module tb_clock_divide_checker;

  typedef struct packed {
    logic [7:0] per;
    logic [7:0] hi;
  } meas_t;

  logic clk_in = 1'b0;
  logic reset;

  always #5 clk_in = ~clk_in;

  clock_divide_checker_if #(.CNT_W(8)) ifa ();
  clock_divide_checker_if #(.CNT_W(8)) ifb ();

  clock_divide_checker #(.DIV(2), .CNT_W(8), .LOCK_COUNT(4)) dut_a (
    .clk_in (clk_in),
    .reset  (reset),
    .chk    (ifa)
  );

  clock_divide_checker #(.DIV(4), .CNT_W(8), .LOCK_COUNT(4)) dut_b (
    .clk_in (clk_in),
    .reset  (reset),
    .chk    (ifb)
  );

  int    checks   = 0;
  int    failures = 0;
  meas_t q_a[$];
  meas_t q_b[$];
  int    vcnt_a = 0;
  int    vcnt_b = 0;
  bit    gen_a  = 1'b0;
  bit    gen_b  = 1'b0;
  int    hi_a   = 1;
  int    lo_a   = 1;
  int    hi_b   = 1;
  int    lo_b   = 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // div_clk generators: one expected entry per generated period
  initial begin
    int ph_a;
    int ph_b;
    ph_a = 0;
    ph_b = 0;
    ifa.div_clk = 1'b0;
    ifb.div_clk = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (!gen_a) begin
        ifa.div_clk = 1'b0;
        ph_a = 0;
      end else begin
        if (ph_a == 0) q_a.push_back({8'(hi_a + lo_a), 8'(hi_a)});
        ifa.div_clk = (ph_a < hi_a);
        ph_a = (ph_a + 1 == hi_a + lo_a) ? 0 : ph_a + 1;
      end
      if (!gen_b) begin
        ifb.div_clk = 1'b0;
        ph_b = 0;
      end else begin
        if (ph_b == 0) q_b.push_back({8'(hi_b + lo_b), 8'(hi_b)});
        ifb.div_clk = (ph_b < hi_b);
        ph_b = (ph_b + 1 == hi_b + lo_b) ? 0 : ph_b + 1;
      end
    end
  end

  // monitors
  initial begin
    meas_t m;
    forever begin
      @(negedge clk_in);
      if (ifa.period_valid === 1'b1) begin
        vcnt_a++;
        if (q_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_valid: got period %0d high_len %0d with nothing expected",
                   ifa.period, ifa.high_len);
        end else begin
          m = q_a.pop_front();
          check("a_period", 32'(ifa.period), 32'(m.per));
          check("a_high_len", 32'(ifa.high_len), 32'(m.hi));
        end
      end
      if (ifb.period_valid === 1'b1) begin
        vcnt_b++;
        if (q_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_valid: got period %0d high_len %0d with nothing expected",
                   ifb.period, ifb.high_len);
        end else begin
          m = q_b.pop_front();
          check("b_period", 32'(ifb.period), 32'(m.per));
          check("b_high_len", 32'(ifb.high_len), 32'(m.hi));
        end
      end
    end
  end

  task automatic wait_lock_a(output int at, input int limit);
    at = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk_in);
      if (at == 0 && ifa.locked === 1'b1) at = i;
    end
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_locked"}, 32'(ifa.locked), 0);
    check({tag, "_err"}, 32'(ifa.err), 0);
    check({tag, "_period"}, 32'(ifa.period), 0);
    check({tag, "_high_len"}, 32'(ifa.high_len), 0);
    check({tag, "_valid"}, 32'(ifa.period_valid), 0);
  endtask

  // n full periods from ACQ on DUT b: expect n-1 reports
  task automatic run_b(input int hi, input int lo, input int n, input string tag,
                       output bit ever_locked);
    int base;
    hi_b = hi;
    lo_b = lo;
    base = vcnt_b;
    ever_locked = 1'b0;
    gen_b = 1'b1;
    for (int i = 0; i < n * (hi + lo); i++) begin
      @(negedge clk_in);
      if (ifb.locked === 1'b1) ever_locked = 1'b1;
    end
    gen_b = 1'b0;
    repeat (16) @(negedge clk_in);
    check({tag, "_valid_count"}, 32'(vcnt_b - base), 32'(n - 1));
    q_b.delete();
  endtask

  initial begin
    int base;
    int lock_at;
    int err_at;
    bit ever;

    reset   = 1'b1;
    ifa.en  = 1'b0;
    ifb.en  = 1'b0;
    repeat (3) @(negedge clk_in);
    check_zero_a("rst");
    check("rst_b_locked", 32'(ifb.locked), 0);
    check("rst_b_valid", 32'(ifb.period_valid), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);

    // DIV=2 toggle: lock, then stall -> err
    ifa.en = 1'b1;
    repeat (3) @(negedge clk_in);
    base  = vcnt_a;
    gen_a = 1'b1;
    wait_lock_a(lock_at, 20);
    gen_a = 1'b0;
    check_range("a_first_lock_latency", lock_at, 1, 14);
    check("a_err_while_locked", 32'(ifa.err), 0);
    err_at = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk_in);
      if (err_at == 0 && ifa.err === 1'b1) begin
        err_at = i;
        check("a_locked_at_err", 32'(ifa.locked), 0);
      end
    end
    check_range("a_err_latency", err_at, 1, 9);
    check("a_valid_count", 32'(vcnt_a - base), 9);
    repeat (5) @(negedge clk_in);
    check("a_err_hold", 32'(ifa.err), 1);
    check("a_locked_hold", 32'(ifa.locked), 0);
    q_a.delete();

    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    check_zero_a("rst_err");

    // free-running relock after reset
    gen_a = 1'b1;
    wait_lock_a(lock_at, 20);
    check_range("a_relock_latency", lock_at, 1, 16);
    repeat (4) @(negedge clk_in);
    check("a_still_locked", 32'(ifa.locked), 1);
    check("a_no_err", 32'(ifa.err), 0);

    // en low for 3 cycles
    ifa.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("a_en0_locked", 32'(ifa.locked), 0);
      check("a_en0_valid", 32'(ifa.period_valid), 0);
    end
    ifa.en = 1'b1;
    wait_lock_a(lock_at, 20);
    check_range("a_en_relock_latency", lock_at, 10, 14);

    // reset mid-lock
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    check_zero_a("rst_lock");
    wait_lock_a(lock_at, 20);
    check_range("a_rst_relock_latency", lock_at, 1, 16);
    gen_a  = 1'b0;
    ifa.en = 1'b0;
    repeat (12) @(negedge clk_in);
    q_a.delete();

    // DIV=4 on dut_b
    ifb.en = 1'b1;
    repeat (3) @(negedge clk_in);
    run_b(3, 3, 6, "b_p6", ever);
    check("b_p6_never_locked", 32'(ever), 0);
    check("b_p6_err", 32'(ifb.err), 0);
    run_b(1, 3, 6, "b_duty", ever);
    check("b_duty_never_locked", 32'(ever), 0);
    check("b_duty_err", 32'(ifb.err), 0);
    run_b(2, 2, 8, "b_good", ever);
    check("b_good_locked", 32'(ever), 1);
    check("b_good_stall_err", 32'(ifb.err), 1);
    check("b_good_stall_locked", 32'(ifb.locked), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_divide_checker.md
Name: clock_divide_checker

Overview:
- Checker at the receiving end of a divided clock: samples a divided clock (e.g. the output of the x2 divider) as data in the fast clk_in domain.
- Measures its period and high time in clk_in cycles and compares both against the expected divide ratio.
- Reports lock after LOCK_COUNT consecutive good periods; flags loss of clock or ratio error once locked.
- Used in-system as a divider health monitor and on benches as a self-checking sink for divider blocks.

Parameters:
- DIV, 2, expected divide ratio; even, >= 2; expected period = DIV, expected high time = DIV/2.
- CNT_W, 8, width of measurement counters and outputs; must hold 2*DIV.
- LOCK_COUNT, 4, consecutive good periods required to assert locked; >= 1.

Ports:
- clk_in  input  1  fast reference clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  checker enable; low forces IDLE.
- div_clk  input  1  divided clock under test, sampled as data.
- locked  output  1  high while in LOCKED.
- err  output  1  sticky error; cleared only by reset.
- period  output  CNT_W  last measured full period in clk_in cycles.
- high_len  output  CNT_W  last measured high time in clk_in cycles.
- period_valid  output  1  one-cycle pulse when period/high_len update.

Behaviour:
- Reset (synchronous): state=IDLE; locked, err, period, high_len, period_valid, run_cnt, good_cnt and sample registers all 0.
- Sampling: s = registered div_clk; s_prev = s delayed one cycle. rise = s & ~s_prev; fall = ~s & s_prev.
- run_cnt:
  - On rise, load 1.
  - Otherwise increment, saturating at all-ones.
  - On fall, high_len_tmp = run_cnt.
  - On rise, measured period = run_cnt.
- Good period: period == DIV and high_len_tmp == DIV/2. Exact match, no tolerance.
- Timeout: run_cnt reaches 2*DIV with no rise.
- States: IDLE, ACQ, MEAS, LOCKED, ERR.
  - IDLE: en=1 -> ACQ.
  - ACQ: first rise -> MEAS with good_cnt=0. No measurement reported for this rise (phase unknown).
  - MEAS: each later rise reports a measurement. Good -> good_cnt+1; when good_cnt reaches LOCK_COUNT -> LOCKED. Bad -> good_cnt=0, stay MEAS. Timeout -> ACQ, good_cnt=0.
  - LOCKED: good rise -> stay. Bad rise or timeout -> ERR.
  - ERR: holds until en=0 or reset.
  - en=0 in any state -> IDLE next cycle; good_cnt cleared.
- Outputs:
  - locked = (state==LOCKED), registered.
  - err set on the clock edge entering ERR; stays 1 through IDLE/ACQ until reset.
- Measurement reporting: on each reported rise, period, high_len and period_valid=1 are registered on that edge (visible the following cycle). period_valid is 0 otherwise, including in IDLE and ACQ.
- Simultaneous events: en=0 beats any rise/timeout in the same cycle. Reset beats everything.
- Reset mid-lock: all outputs 0 the cycle after reset is sampled; err also cleared.
- Latency: with DIV=2, LOCK_COUNT=4, no synchronizer, locked rises 12 cycles after en rises with a running div_clk (±2 depending on div_clk phase).

Optional Feature:
- CLK_DIV_CHECK_SYNC_EN
  - Defined: div_clk passes through a 2-flop synchronizer before the s register. Adds 2 cycles of latency to every edge detect and to locked/err; measured values are unchanged. Required when div_clk comes from an unrelated clock domain.
  - Undefined: single sample register only. div_clk must be synchronous to clk_in.

Test Plan:
- DIV=2: div_clk toggles every clk_in edge, en=1 -> locked=1 within 14 cycles; period_valid pulses every 2 cycles with period=2, high_len=1; err=0.
- Locked at DIV=2, then div_clk held 0 -> err=1 and locked=0 within 4+3 cycles (+2 with sync); both hold until reset.
- DIV=4: div_clk period 6 (3 high/3 low) -> never locks; period_valid pulses with period=6, high_len=3; err=0.
- DIV=4: duty fault, 1 high/3 low -> period=4, high_len=1; locked stays 0.
- Locked, then reset for 1 cycle -> locked, err, period, high_len all 0 next cycle; relocks after release.
- Locked, then en=0 for 3 cycles -> locked=0 next cycle, no period_valid pulses; en=1 -> relock with the same latency as first lock.
